riscv_mem_arbiter: RTL and testbench

- Shares the single unified instruction/data memory of the multicycle RISC-V core between two requesters:
  - the core's memory port (fetch and load/store);
  - a program loader/debug port that preloads or inspects memory.
- Performs round-robin arbitration and sequences each access through a fixed-latency memory.
- Returns a one-cycle done pulse and registered read data.
- Drives a stall signal the core controller uses to hold its FSM while an access is in flight.

---
 rtl/riscv_mem_arbiter_if.sv | 49 ++++
 rtl/riscv_mem_arbiter.sv | 109 ++++++++++
 tb/tb_riscv_mem_arbiter.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_mem_arbiter_if.sv
// Bundle of the core port, loader port and memory port shared by the arbiter.
// The arbiter connects through slave; requesters and the memory model use master.
interface riscv_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic [DATA_W-1:0] c_rdata;
  logic              c_done;
  logic              core_stall;

  logic              l_req;
  logic              l_we;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic [DATA_W-1:0] l_rdata;
  logic              l_done;

  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;

  logic              owner;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    output c_rdata, c_done, core_stall,
    input  l_req, l_we, l_addr, l_wdata,
    output l_rdata, l_done,
    output m_en, m_we, m_addr, m_wdata,
    input  m_rdata,
    output owner
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    input  c_rdata, c_done, core_stall,
    output l_req, l_we, l_addr, l_wdata,
    input  l_rdata, l_done,
    input  m_en, m_we, m_addr, m_wdata,
    output m_rdata,
    input  owner
  );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Round-robin arbiter between core and loader in front of a fixed-latency memory.
// Grant edge to done is 1+MEM_LAT cycles; the loser holds req and core_stall stays high until c_done.
module riscv_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input logic                clk,
  input logic                rst,
  riscv_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  localparam logic [2:0] CNT_LOAD = 3'(MEM_LAT - 1);

  state_t            state;
  state_t            state_nxt;
  logic [2:0]        cnt;
  logic              we_q;
  logic              owner_q;
  logic              last_owner;
  logic [ADDR_W-1:0] m_addr_q;
  logic [DATA_W-1:0] m_wdata_q;
  logic [DATA_W-1:0] c_rdata_q;
  logic [DATA_W-1:0] l_rdata_q;
  logic              grant;
  logic              winner;

  // On a tie the requester that did not win last time goes next.
  assign winner = (bus.c_req && bus.l_req) ? ~last_owner : bus.l_req;
  assign grant  = (state == IDLE) && (bus.c_req || bus.l_req);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = ACCESS;
      ACCESS:  state_nxt = (MEM_LAT > 1) ? WAIT : DONE;
      WAIT:    if (cnt == 3'd1) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.m_en   = 1'b0;
    bus.m_we   = 1'b0;
    bus.c_done = 1'b0;
    bus.l_done = 1'b0;
    case (state)
      ACCESS: begin
        bus.m_en = 1'b1;
        bus.m_we = we_q;
      end
      DONE: begin
        bus.c_done = ~owner_q;
        bus.l_done = owner_q;
      end
      default: ;
    endcase
  end

  assign bus.core_stall = bus.c_req & ~bus.c_done;
  assign bus.m_addr     = m_addr_q;
  assign bus.m_wdata    = m_wdata_q;
  assign bus.c_rdata    = c_rdata_q;
  assign bus.l_rdata    = l_rdata_q;
  assign bus.owner      = owner_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      we_q       <= 1'b0;
      owner_q    <= 1'b1;
      last_owner <= 1'b1;
      cnt        <= '0;
      c_rdata_q  <= '0;
      l_rdata_q  <= '0;
    end else begin
      if (grant) begin
        m_addr_q  <= winner ? bus.l_addr  : bus.c_addr;
        m_wdata_q <= winner ? bus.l_wdata : bus.c_wdata;
        we_q      <= winner ? bus.l_we    : bus.c_we;
        owner_q   <= winner;
      end
      if (state == ACCESS) begin
        cnt <= CNT_LOAD;
      end else if (state == WAIT) begin
        cnt <= cnt - 3'd1;
      end
      // m_rdata is valid exactly on the edge that enters DONE.
      if ((state_nxt == DONE) && !we_q) begin
        if (owner_q) l_rdata_q <= bus.m_rdata;
        else         c_rdata_q <= bus.m_rdata;
      end
      if (state == DONE) begin
        last_owner <= owner_q;
      end
    end
  end
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Drives two arbiters (MEM_LAT 1 and 3) with directed and random traffic against behavioural memories.
module tb_riscv_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LAT_A = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  riscv_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifa ();
  riscv_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifb ();

  riscv_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT_A)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  riscv_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3))     dut_b (.clk(clk), .rst(rst), .bus(ifb));

  function automatic logic [31:0] init_word(int i);
    return (i == 16) ? 32'h0050_0093 : (32'h5A00_0000 | 32'(i));
  endfunction

  function automatic logic [31:0] fb(logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory A: single-cycle read, write lands on the ACCESS edge.
  logic [31:0] mem_a [0:255];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) mem_a[i] <= init_word(i);
    end else if (ifa.m_en && ifa.m_we) begin
      mem_a[ifa.m_addr[7:0]] <= ifa.m_wdata;
    end
  end
  assign ifa.m_rdata = ifa.m_en ? mem_a[ifa.m_addr[7:0]] : 32'hBAD0_BAD0;

  // Memory B: read-only, data valid two cycles after the ACCESS cycle.
  logic [32:0] pb1, pb2;
  always @(posedge clk) begin
    pb1 <= ifb.m_en ? {1'b1, fb(ifb.m_addr)} : 33'h0;
    pb2 <= pb1;
  end
  assign ifb.m_rdata = pb2[32] ? pb2[31:0] : 32'hBAD0_BAD0;

  task automatic clear_inputs();
    ifa.c_req = 0; ifa.c_we = 0; ifa.c_addr = 0; ifa.c_wdata = 0;
    ifa.l_req = 0; ifa.l_we = 0; ifa.l_addr = 0; ifa.l_wdata = 0;
    ifb.c_req = 0; ifb.c_we = 0; ifb.c_addr = 0; ifb.c_wdata = 0;
    ifb.l_req = 0; ifb.l_we = 0; ifb.l_addr = 0; ifb.l_wdata = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 0;
    #1;
    tests++; if ({ifa.m_en, ifa.m_we, ifa.c_done, ifa.l_done, ifa.core_stall} !== 5'b0) begin
      fails++; $display("FAIL reset_ctrl_a: got %b exp 00000", {ifa.m_en, ifa.m_we, ifa.c_done, ifa.l_done, ifa.core_stall}); end
    tests++; if ({ifa.m_addr, ifa.m_wdata, ifa.c_rdata, ifa.l_rdata} !== 128'h0) begin
      fails++; $display("FAIL reset_data_a: got %h exp 0", {ifa.m_addr, ifa.m_wdata, ifa.c_rdata, ifa.l_rdata}); end
    tests++; if ({ifb.m_en, ifb.m_we, ifb.c_done, ifb.l_done, ifb.m_addr, ifb.c_rdata} !== 68'h0) begin
      fails++; $display("FAIL reset_b: got %h exp 0", {ifb.m_en, ifb.m_we, ifb.c_done, ifb.l_done, ifb.m_addr, ifb.c_rdata}); end
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_core_read();
    do_reset();
    ifa.c_req = 1; ifa.c_we = 0; ifa.c_addr = 32'h10;
    #1;
    tests++; if (ifa.core_stall !== 1'b1 || ifa.m_en !== 1'b0) begin
      fails++; $display("FAIL cr_cycle0: got stall=%b en=%b exp stall=1 en=0", ifa.core_stall, ifa.m_en); end
    @(negedge clk);
    tests++; if ({ifa.m_en, ifa.m_we, ifa.c_done, ifa.core_stall, ifa.owner} !== 5'b10010) begin
      fails++; $display("FAIL cr_cycle1_ctrl: got %b exp 10010", {ifa.m_en, ifa.m_we, ifa.c_done, ifa.core_stall, ifa.owner}); end
    tests++; if (ifa.m_addr !== 32'h10) begin
      fails++; $display("FAIL cr_cycle1_addr: got %h exp 00000010", ifa.m_addr); end
    @(negedge clk);
    tests++; if ({ifa.m_en, ifa.c_done, ifa.l_done, ifa.core_stall} !== 4'b0100) begin
      fails++; $display("FAIL cr_cycle2_ctrl: got %b exp 0100", {ifa.m_en, ifa.c_done, ifa.l_done, ifa.core_stall}); end
    tests++; if (ifa.c_rdata !== 32'h0050_0093) begin
      fails++; $display("FAIL cr_rdata: got %h exp 00500093", ifa.c_rdata); end
    ifa.c_req = 0;
    @(negedge clk);
    tests++; if (ifa.c_done !== 1'b0 || ifa.c_rdata !== 32'h0050_0093) begin
      fails++; $display("FAIL cr_after: got done=%b rdata=%h exp done=0 rdata=00500093", ifa.c_done, ifa.c_rdata); end
  endtask

  task automatic test_loader_write();
    int en_cnt = 0, wr_cnt = 0, done_cnt = 0, bad_rd = 0, cdone_cnt = 0, n = 0;
    do_reset();
    ifa.l_req = 1; ifa.l_we = 1; ifa.l_addr = 32'h20; ifa.l_wdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ifa.m_en) en_cnt++;
      if (ifa.m_en && ifa.m_we && ifa.m_addr == 32'h20 && ifa.m_wdata == 32'hDEAD_BEEF) wr_cnt++;
      if (ifa.l_done) begin done_cnt++; ifa.l_req = 0; end
      if (ifa.l_rdata !== 32'h0) bad_rd++;
      if (ifa.c_done) cdone_cnt++;
    end
    tests++; if (en_cnt != 1 || wr_cnt != 1) begin
      fails++; $display("FAIL lw_strobes: got en=%0d wr=%0d exp 1 1", en_cnt, wr_cnt); end
    tests++; if (done_cnt != 1 || cdone_cnt != 0) begin
      fails++; $display("FAIL lw_done: got l=%0d c=%0d exp 1 0", done_cnt, cdone_cnt); end
    tests++; if (bad_rd != 0) begin
      fails++; $display("FAIL lw_rdata_kept: got %0d changed cycles exp 0", bad_rd); end
    ifa.c_req = 1; ifa.c_we = 0; ifa.c_addr = 32'h20;
    do begin @(negedge clk); n++; end while (!ifa.c_done && n < 10);
    tests++; if (ifa.c_done !== 1'b1 || ifa.c_rdata !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL lw_readback: got done=%b rdata=%h exp 1 deadbeef", ifa.c_done, ifa.c_rdata); end
    ifa.c_req = 0;
  endtask

  task automatic test_alternation();
    int g = 0;
    logic exp_owner = 1'b0;
    do_reset();
    ifa.c_req = 1; ifa.c_we = 0; ifa.c_addr = 32'h04;
    ifa.l_req = 1; ifa.l_we = 0; ifa.l_addr = 32'h08;
    for (int k = 0; k < 40 && g < 8; k++) begin
      @(negedge clk);
      if (ifa.m_en) begin
        tests++; if (ifa.owner !== exp_owner || ifa.m_addr !== (exp_owner ? 32'h08 : 32'h04)) begin
          fails++; $display("FAIL alt_grant%0d: got owner=%b addr=%h exp owner=%b", g, ifa.owner, ifa.m_addr, exp_owner); end
        exp_owner = ~exp_owner;
        g++;
      end
    end
    tests++; if (g != 8) begin
      fails++; $display("FAIL alt_count: got %0d grants exp 8", g); end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    int en_cnt = 0, done1 = -1, en2 = -1, n = 0;
    do_reset();
    ifa.c_req = 1; ifa.c_we = 0; ifa.c_addr = 32'h10;
    for (int cyc = 1; cyc <= 20 && en2 < 0; cyc++) begin
      @(negedge clk);
      if (ifa.m_en) begin en_cnt++; if (en_cnt == 2) en2 = cyc; end
      if (ifa.c_done && done1 < 0) done1 = cyc;
    end
    tests++; if (done1 != 2 || en2 != 4) begin
      fails++; $display("FAIL b2b_timing: got done1=%0d en2=%0d exp 2 4", done1, en2); end
    do begin @(negedge clk); n++; end while (!ifa.c_done && n < 10);
    tests++; if (ifa.c_done !== 1'b1 || ifa.c_rdata !== 32'h0050_0093) begin
      fails++; $display("FAIL b2b_second: got done=%b rdata=%h exp 1 00500093", ifa.c_done, ifa.c_rdata); end
    ifa.c_req = 0;
  endtask

  task automatic test_mem_lat3();
    int en_cnt = 0, en_cyc = -1, done_cyc = -1, stall_cnt = 0;
    do_reset();
    ifb.c_req = 1; ifb.c_we = 0; ifb.c_addr = 32'h44;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      if (ifb.m_en) begin en_cnt++; en_cyc = cyc; end
      if (ifb.core_stall) stall_cnt++;
      if (ifb.c_done) begin if (done_cyc < 0) done_cyc = cyc; ifb.c_req = 0; end
    end
    tests++; if (en_cnt != 1 || en_cyc != 1) begin
      fails++; $display("FAIL lat3_en: got cnt=%0d cyc=%0d exp 1 1", en_cnt, en_cyc); end
    tests++; if (done_cyc != 4 || stall_cnt != 3) begin
      fails++; $display("FAIL lat3_done: got done=%0d stall=%0d exp 4 3", done_cyc, stall_cnt); end
    tests++; if (ifb.c_rdata !== fb(32'h44)) begin
      fails++; $display("FAIL lat3_rdata: got %h exp %h", ifb.c_rdata, fb(32'h44)); end
  endtask

  task automatic test_reset_mid();
    int early = 0, done_cyc = -1;
    do_reset();
    ifb.l_req = 1; ifb.l_we = 0; ifb.l_addr = 32'h30; ifb.l_wdata = 32'h1234_5678;
    @(negedge clk);
    tests++; if (ifb.m_addr !== 32'h30 || ifb.m_wdata !== 32'h1234_5678) begin
      fails++; $display("FAIL rm_latched: got %h %h exp 00000030 12345678", ifb.m_addr, ifb.m_wdata); end
    @(negedge clk);
    #2 rst = 0;
    #1;
    tests++; if ({ifb.m_en, ifb.m_we, ifb.l_done, ifb.c_done} !== 4'b0 || {ifb.m_addr, ifb.m_wdata, ifb.l_rdata} !== 96'h0) begin
      fails++; $display("FAIL rm_async: got ctrl=%b addr=%h wdata=%h rdata=%h exp zeros",
                        {ifb.m_en, ifb.m_we, ifb.l_done, ifb.c_done}, ifb.m_addr, ifb.m_wdata, ifb.l_rdata); end
    repeat (2) begin @(negedge clk); if (ifb.l_done) early++; end
    rst = 1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      if (ifb.l_done) begin if (done_cyc < 0) done_cyc = cyc; ifb.l_req = 0; end
    end
    tests++; if (early != 0 || done_cyc != 4) begin
      fails++; $display("FAIL rm_reissue: got early=%0d done=%0d exp 0 4", early, done_cyc); end
    tests++; if (ifb.l_rdata !== fb(32'h30)) begin
      fails++; $display("FAIL rm_rdata: got %h exp %h", ifb.l_rdata, fb(32'h30)); end
  endtask

  task automatic test_random();
    logic [31:0] ref_mem [256];
    bit          pend [2];
    bit          rwe [2];
    logic [7:0]  raddr [2];
    logic [31:0] rwd [2];
    logic [31:0] exp_rd [2];
    int          served [2];
    bit          busy = 0, was_done, exp_en, creq_now;
    bit          exp_done [2];
    int          own = 0, last = 1, gnt = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    for (int p = 0; p < 2; p++) begin pend[p] = 0; exp_rd[p] = 0; served[p] = 0; end
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc > 0) @(negedge clk);
      exp_en = busy && (cyc == gnt + 1);
      for (int p = 0; p < 2; p++) exp_done[p] = busy && (own == p) && (cyc == gnt + 1 + LAT_A);
      creq_now = pend[0];
      was_done = exp_done[0] || exp_done[1];
      if (was_done) begin
        if (rwe[own]) ref_mem[raddr[own]] = rwd[own];
        else          exp_rd[own] = ref_mem[raddr[own]];
        pend[own] = 0; last = own; busy = 0; served[own]++;
      end
      tests++; if (ifa.m_en !== exp_en || ifa.m_we !== (exp_en && rwe[own])) begin
        fails++; $display("FAIL rnd_strobe@%0d: got en=%b we=%b exp en=%b", cyc, ifa.m_en, ifa.m_we, exp_en); end
      if (exp_en) begin
        tests++; if (ifa.owner !== own[0] || ifa.m_addr !== {24'h0, raddr[own]} || (rwe[own] && ifa.m_wdata !== rwd[own])) begin
          fails++; $display("FAIL rnd_grant@%0d: got owner=%b addr=%h exp owner=%0d addr=%h", cyc, ifa.owner, ifa.m_addr, own, raddr[own]); end
      end
      tests++; if (ifa.c_done !== exp_done[0] || ifa.l_done !== exp_done[1] || ifa.core_stall !== (creq_now && !exp_done[0])) begin
        fails++; $display("FAIL rnd_done@%0d: got c=%b l=%b stall=%b exp c=%b l=%b", cyc, ifa.c_done, ifa.l_done, ifa.core_stall, exp_done[0], exp_done[1]); end
      tests++; if (ifa.c_rdata !== exp_rd[0] || ifa.l_rdata !== exp_rd[1]) begin
        fails++; $display("FAIL rnd_rdata@%0d: got c=%h l=%h exp c=%h l=%h", cyc, ifa.c_rdata, ifa.l_rdata, exp_rd[0], exp_rd[1]); end
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && cyc < 380 && $urandom_range(0, 2) != 0) begin
          pend[p] = 1; rwe[p] = 1'($urandom_range(0, 1));
          raddr[p] = 8'($urandom_range(0, 31)); rwd[p] = $urandom;
        end
      end
      ifa.c_req = pend[0]; ifa.c_we = rwe[0]; ifa.c_addr = {24'h0, raddr[0]}; ifa.c_wdata = rwd[0];
      ifa.l_req = pend[1]; ifa.l_we = rwe[1]; ifa.l_addr = {24'h0, raddr[1]}; ifa.l_wdata = rwd[1];
      if (!busy && !was_done && (pend[0] || pend[1])) begin
        own  = (pend[0] && pend[1]) ? ((last == 0) ? 1 : 0) : (pend[1] ? 1 : 0);
        busy = 1; gnt = cyc;
      end
    end
    tests++; if (served[0] < 20 || served[1] < 20) begin
      fails++; $display("FAIL rnd_fairness: got core=%0d loader=%0d exp both >= 20", served[0], served[1]); end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_core_read();
    test_loader_write();
    test_alternation();
    test_back_to_back();
    test_mem_lat3();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule
